mole_board_ctrl: RTL and testbench



---
 rtl/mole_board_ctrl.sv | 154 +++++++++++++++
 tb/tb_mole_board_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_board_ctrl.sv
// Whack-a-mole game sequencer: drives the board countdown timer, raises one
// pseudo-random mole per round and keeps score/miss counts for one game.
module mole_board_ctrl #(
    parameter int          N_HOLES   = 8,
    parameter logic [27:0] UP_TIME   = 28'd50_000_000,
    parameter logic [27:0] GAP_TIME  = 28'd25_000_000,
    parameter int          ROUNDS    = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_HOLES-1:0] hit,
    input  logic               time_trigger,
    output logic               load,
    output logic [27:0]        loadval,
    output logic [N_HOLES-1:0] mole,
    output logic [7:0]         score,
    output logic [7:0]         misses,
    output logic               game_over
);

    localparam int          IDX_W     = (N_HOLES > 1) ? $clog2(N_HOLES) : 1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [7:0]  ROUNDS_C  = 8'(ROUNDS);

    typedef enum logic [1:0] {IDLE, GAP, UP, DONE} state_t;

    state_t             state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [7:0]         round_q, round_d;
    logic               load_d;
    logic [27:0]        loadval_d;
    logic [N_HOLES-1:0] mole_d;
    logic [7:0]         score_d;
    logic [7:0]         misses_d;
    logic               game_over_d;

    logic               trig_live;
    logic               hit_correct;
    logic               hit_wrong;
    logic               end_round;
    logic [7:0]         round_inc;
    logic [N_HOLES-1:0] new_mole;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // A trigger arriving while we are reloading the timer belongs to the old
    // countdown, so it is discarded.
    assign trig_live   = time_trigger && !load;
    assign hit_correct = |(hit & mole);
    assign hit_wrong   = (|hit) && !hit_correct;
    assign round_inc   = round_q + 8'd1;
    assign new_mole    = {{(N_HOLES-1){1'b0}}, 1'b1} << lfsr_q[IDX_W-1:0];

    // Galois LFSR free-runs every cycle so mole placement depends on timing.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end

    // Next-state and next-output logic; start overrides every other event.
    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        load_d      = 1'b0;
        loadval_d   = loadval;
        mole_d      = mole;
        score_d     = score;
        misses_d    = misses;
        end_round   = 1'b0;
        game_over_d = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                mole_d = '0;
            end
            GAP: begin
                if (trig_live) begin
                    mole_d    = new_mole;
                    load_d    = 1'b1;
                    loadval_d = UP_TIME;
                    state_d   = UP;
                end
            end
            UP: begin
                if (hit_correct) begin
                    score_d   = sat_inc(score);
                    end_round = 1'b1;
                end else if (hit_wrong) begin
                    misses_d  = sat_inc(misses);
                end else if (trig_live) begin
                    misses_d  = sat_inc(misses);
                    end_round = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                mole_d  = '0;
            end
        endcase

        if (end_round) begin
            mole_d  = '0;
            round_d = round_inc;
            if (round_inc == ROUNDS_C) begin
                state_d = DONE;
            end else begin
                load_d    = 1'b1;
                loadval_d = GAP_TIME;
                state_d   = GAP;
            end
        end

        if (start) begin
            score_d   = 8'd0;
            misses_d  = 8'd0;
            round_d   = 8'd0;
            mole_d    = '0;
            load_d    = 1'b1;
            loadval_d = GAP_TIME;
            state_d   = GAP;
        end

        game_over_d = (state_d == DONE);
    end

    // State, LFSR, round counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            lfsr_q    <= LFSR_SEED;
            round_q   <= 8'd0;
            load      <= 1'b0;
            loadval   <= 28'd0;
            mole      <= '0;
            score     <= 8'd0;
            misses    <= 8'd0;
            game_over <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            round_q   <= round_d;
            load      <= load_d;
            loadval   <= loadval_d;
            mole      <= mole_d;
            score     <= score_d;
            misses    <= misses_d;
            game_over <= game_over_d;
        end
    end

endmodule

// File: tb/tb_mole_board_ctrl.sv
// Bench for mole_board_ctrl: behavioural board timer, directed game scenarios
// and a randomized phase, all checked against a cycle-level game model.
module tb_mole_board_ctrl;

    localparam int          NH   = 8;
    localparam logic [27:0] UPT  = 28'd10;
    localparam logic [27:0] GAPT = 28'd5;
    localparam int          RND  = 3;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  hit;
    logic        time_trigger;
    logic        load;
    logic [27:0] loadval;
    logic [7:0]  mole;
    logic [7:0]  score;
    logic [7:0]  misses;
    logic        game_over;

    logic        force_trig;
    logic        timer_trig;
    logic [27:0] cnt;

    int checks = 0;
    int errors = 0;

    // Reference model of the game as the player sees it.
    logic        e_load;
    logic [27:0] e_loadval;
    logic [7:0]  e_mole;
    logic [7:0]  e_score;
    logic [7:0]  e_misses;
    logic        e_over;
    bit          m_running;
    int          m_round;
    logic [15:0] m_lfsr;

    mole_board_ctrl #(
        .N_HOLES(NH), .UP_TIME(UPT), .GAP_TIME(GAPT),
        .ROUNDS(RND), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .hit(hit),
        .time_trigger(time_trigger), .load(load), .loadval(loadval),
        .mole(mole), .score(score), .misses(misses), .game_over(game_over)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    assign time_trigger = timer_trig | force_trig;

    // Behavioural board countdown timer: pulses once when it counts down to zero.
    always @(posedge clk) begin
        if (rst) begin
            cnt        <= 28'd0;
            timer_trig <= 1'b0;
        end else if (load) begin
            cnt        <= loadval;
            timer_trig <= 1'b0;
        end else if (cnt != 28'd0) begin
            cnt        <= cnt - 28'd1;
            timer_trig <= (cnt == 28'd1);
        end else begin
            timer_trig <= 1'b0;
        end
    end

    function automatic logic [7:0] satInc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    task automatic modelStep(input bit s, input logic [7:0] h, input bit t, input bit r);
        bit live;
        int idx;
        bit finish;
        if (r) begin
            e_load = 0; e_loadval = 0; e_mole = 0; e_score = 0; e_misses = 0;
            e_over = 0; m_running = 0; m_round = 0; m_lfsr = SEED;
            return;
        end
        live   = t && !e_load;
        idx    = int'(m_lfsr % 16'(NH));
        m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
        e_load = 0;
        finish = 0;
        if (s) begin
            e_score = 0; e_misses = 0; m_round = 0; e_mole = 0;
            e_load = 1; e_loadval = GAPT; e_over = 0; m_running = 1;
        end else if (m_running) begin
            if (e_mole == 0) begin
                if (live) begin
                    e_mole = 8'(1 << idx); e_load = 1; e_loadval = UPT;
                end
            end else if ((h & e_mole) != 0) begin
                e_score = satInc(e_score); finish = 1;
            end else if (h != 0) begin
                e_misses = satInc(e_misses);
            end else if (live) begin
                e_misses = satInc(e_misses); finish = 1;
            end
            if (finish) begin
                e_mole = 0;
                m_round++;
                if (m_round == RND) begin
                    m_running = 0; e_over = 1;
                end else begin
                    e_load = 1; e_loadval = GAPT;
                end
            end
        end
    endtask

    task automatic check1(input string tag, input logic [27:0] obs, input logic [27:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        check1("load",      28'(load),      28'(e_load));
        check1("loadval",   loadval,        e_loadval);
        check1("mole",      28'(mole),      28'(e_mole));
        check1("score",     28'(score),     28'(e_score));
        check1("misses",    28'(misses),    28'(e_misses));
        check1("game_over", 28'(game_over), 28'(e_over));
    endtask

    // One clock cycle: drive at negedge, model the edge, check at next negedge.
    task automatic applyStimulus(input bit s, input logic [7:0] h, input bit ft, input bit r);
        logic t;
        start = s; hit = h; force_trig = ft; rst = r;
        #1;
        t = time_trigger;
        @(posedge clk);
        modelStep(s, h, t, r);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic waitMole(input string tag);
        int n = 0;
        while (mole === 8'd0 && n < 40) begin
            applyStimulus(0, 8'd0, 0, 0);
            n++;
        end
        checks++;
        if (mole === 8'd0) begin
            errors++;
            $error("[TB] FAIL %s: observed no mole expected mole within 40 cycles", tag);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 8'd0, 0, 0);
    endtask

    initial begin
        logic [7:0] wrong;
        logic [7:0] h;
        bit         s, r, ft;
        rst = 1; start = 0; hit = 0; force_trig = 0;
        e_load = 0; e_loadval = 0; e_mole = 0; e_score = 0; e_misses = 0; e_over = 0;
        m_running = 0; m_round = 0; m_lfsr = SEED;
        @(negedge clk);

        $display("[TB] reset and first mole");
        applyStimulus(0, 8'd0, 0, 1);
        applyStimulus(0, 8'd0, 0, 1);
        applyStimulus(1, 8'd0, 0, 0);
        waitMole("first_mole");

        $display("[TB] correct hit every round");
        for (int k = 0; k < RND; k++) begin
            applyStimulus(0, e_mole, 0, 0);
            if (k < RND - 1) waitMole("round_mole");
        end
        idle(12);

        $display("[TB] no hits");
        applyStimulus(1, 8'd0, 0, 0);
        for (int i = 0; i < 80 && !e_over; i++) applyStimulus(0, 8'd0, 0, 0);
        check1("timeout_misses", 28'(misses), 28'(RND));
        idle(3);

        $display("[TB] wrong hits and hit with trigger");
        applyStimulus(1, 8'd0, 0, 0);
        waitMole("wrong_mole");
        wrong = {e_mole[6:0], e_mole[7]} | {e_mole[4:0], e_mole[7:5]};
        applyStimulus(0, wrong, 0, 0);
        applyStimulus(0, wrong, 0, 0);
        applyStimulus(0, e_mole, 1, 0);
        waitMole("after_hit_trig");

        $display("[TB] stale trigger and restart in UP");
        applyStimulus(1, 8'd0, 0, 0);
        applyStimulus(0, 8'd0, 1, 0);
        waitMole("stale_gap_mole");
        applyStimulus(0, 8'd0, 1, 0);
        applyStimulus(0, e_mole, 0, 0);
        waitMole("stale_mole2");
        applyStimulus(0, e_mole, 0, 0);
        waitMole("stale_mole3");
        check1("score_before_restart", 28'(score), 28'd2);
        applyStimulus(1, 8'd0, 0, 0);
        idle(2);

        $display("[TB] reset in UP and repeatable first mole");
        waitMole("rst_mole");
        applyStimulus(0, 8'd0, 0, 1);
        for (int rep = 0; rep < 2; rep++) begin
            applyStimulus(0, 8'd0, 0, 1);
            idle(4);
            applyStimulus(1, 8'd0, 0, 0);
            waitMole("repeat_mole");
        end

        $display("[TB] randomized play");
        for (int i = 0; i < 600; i++) begin
            s  = ($urandom_range(0, 59) == 0) || (e_over && $urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 199) == 0);
            ft = ($urandom_range(0, 24) == 0);
            h  = 8'd0;
            if ($urandom_range(0, 5) == 0) h = 8'($urandom_range(1, 255));
            else if ($urandom_range(0, 7) == 0) h = e_mole;
            applyStimulus(s, h, ft, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run can never hang.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
